// File: rtl/data_ram_port_arbiter_if.sv
// Signal bundle shared by the core memory stage, the auxiliary master,
// the data-RAM arbiter and the data RAM itself.
interface data_ram_port_arbiter_if #(parameter int DW = 64);
    logic          i_core_req, i_core_we, i_core_store_byte, i_core_store_half;
    logic [DW-1:0] i_core_addr, i_core_wdata;
    logic          o_core_ack, o_core_stall;
    logic [DW-1:0] o_core_rdata;

    logic          i_aux_req, i_aux_we, i_aux_store_byte, i_aux_store_half, i_aux_lock;
    logic [DW-1:0] i_aux_addr, i_aux_wdata;
    logic          o_aux_ack;
    logic [DW-1:0] o_aux_rdata;

    logic          o_mem_write, o_store_byte, o_store_half;
    logic [DW-1:0] o_mem_addr, o_mem_data, i_mem_rdata;

    // arbiter side
    modport slave (
        input  i_core_req, i_core_we, i_core_addr, i_core_wdata, i_core_store_byte, i_core_store_half,
        output o_core_ack, o_core_rdata, o_core_stall,
        input  i_aux_req, i_aux_we, i_aux_addr, i_aux_wdata, i_aux_store_byte, i_aux_store_half, i_aux_lock,
        output o_aux_ack, o_aux_rdata,
        output o_mem_write, o_mem_addr, o_mem_data, o_store_byte, o_store_half,
        input  i_mem_rdata
    );

    // requester / RAM side
    modport master (
        output i_core_req, i_core_we, i_core_addr, i_core_wdata, i_core_store_byte, i_core_store_half,
        input  o_core_ack, o_core_rdata, o_core_stall,
        output i_aux_req, i_aux_we, i_aux_addr, i_aux_wdata, i_aux_store_byte, i_aux_store_half, i_aux_lock,
        input  o_aux_ack, o_aux_rdata,
        input  o_mem_write, o_mem_addr, o_mem_data, o_store_byte, o_store_half,
        output i_mem_rdata
    );
endinterface

// File: rtl/data_ram_port_arbiter.sv
// Round-robin arbiter sharing the single data-RAM port between the core memory
// stage and an auxiliary master, with a bounded aux lock burst.
module data_ram_port_arbiter #(
    parameter logic [1:0] XLEN      = 2'b10,
    parameter int         MAX_BURST = 8,
    parameter int         CNT_W     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clk_en,
    data_ram_port_arbiter_if.slave  bus
);
    localparam int DW = 1 << (XLEN + 4);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CORE = 2'd1;
    localparam logic [1:0] S_AUX  = 2'd2;

    logic [1:0]       state, nxt_state;
    logic             last_aux;
    logic [CNT_W-1:0] burst_cnt;
    logic             cmd_we, cmd_byte, cmd_half;
    logic [DW-1:0]    cmd_addr, cmd_wdata;
    logic             core_ack, aux_ack;
    logic [DW-1:0]    core_rdata, aux_rdata;
    logic             grant_core, grant_aux, burst_ok, busy;

    assign burst_ok = bus.i_aux_lock && (burst_cnt < MAX_CNT);

    // The requester being served in CORE/AUX is never eligible at its exit edge:
    // its req still belongs to the transaction being acknowledged.
    always_comb begin
        grant_core = 1'b0;
        grant_aux  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_core_req && bus.i_aux_req) begin
                    if (burst_ok || !last_aux) grant_aux  = 1'b1;
                    else                       grant_core = 1'b1;
                end else begin
                    grant_core = bus.i_core_req;
                    grant_aux  = bus.i_aux_req;
                end
            end
            S_CORE:  grant_aux  = bus.i_aux_req;
            S_AUX:   grant_core = bus.i_core_req && !burst_ok;
            default: ;
        endcase
        nxt_state = grant_core ? S_CORE : (grant_aux ? S_AUX : S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            last_aux   <= 1'b1;
            burst_cnt  <= '0;
            cmd_we     <= 1'b0;
            cmd_byte   <= 1'b0;
            cmd_half   <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            core_ack   <= 1'b0;
            aux_ack    <= 1'b0;
            core_rdata <= '0;
            aux_rdata  <= '0;
        end else if (i_clk_en) begin
            state    <= nxt_state;
            core_ack <= (state == S_CORE);
            aux_ack  <= (state == S_AUX);
            if (state == S_CORE) core_rdata <= bus.i_mem_rdata;
            if (state == S_AUX)  aux_rdata  <= bus.i_mem_rdata;
            if (grant_core) begin
                cmd_we    <= bus.i_core_we;
                cmd_addr  <= bus.i_core_addr;
                cmd_wdata <= bus.i_core_wdata;
                cmd_byte  <= bus.i_core_store_byte;
                cmd_half  <= bus.i_core_store_half;
                last_aux  <= 1'b0;
            end else if (grant_aux) begin
                cmd_we    <= bus.i_aux_we;
                cmd_addr  <= bus.i_aux_addr;
                cmd_wdata <= bus.i_aux_wdata;
                cmd_byte  <= bus.i_aux_store_byte;
                cmd_half  <= bus.i_aux_store_half;
                last_aux  <= 1'b1;
            end
            // Burst counts only aux grants that actually keep the core waiting.
            if (!bus.i_aux_lock || grant_core)
                burst_cnt <= '0;
            else if (grant_aux && bus.i_core_req && burst_cnt != MAX_CNT)
                burst_cnt <= burst_cnt + 1'b1;
        end
    end

    assign busy = (state == S_CORE) || (state == S_AUX);

    assign bus.o_mem_write  = busy && cmd_we && !i_rst;
    assign bus.o_store_byte = busy && cmd_byte;
    assign bus.o_store_half = busy && cmd_half;
    assign bus.o_mem_addr   = cmd_addr;
    assign bus.o_mem_data   = cmd_wdata;
    assign bus.o_core_ack   = core_ack;
    assign bus.o_aux_ack    = aux_ack;
    assign bus.o_core_rdata = core_rdata;
    assign bus.o_aux_rdata  = aux_rdata;
    assign bus.o_core_stall = bus.i_core_req && !core_ack;
endmodule

// File: tb/tb_data_ram_port_arbiter.sv
// Bench for data_ram_port_arbiter: directed scenarios followed by randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_data_ram_port_arbiter;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst, clk_en;
    always #5 clk = ~clk;

    data_ram_port_arbiter_if #(.DW(64)) bus();

    data_ram_port_arbiter #(.XLEN(2'b10), .MAX_BURST(MAXB), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .bus(bus)
    );

    logic [63:0] ram [512];
    assign bus.i_mem_rdata = ram[bus.o_mem_addr[8:0]];

    int nerr = 0, nchk = 0, wr40 = 0;

    // reference model: who owns the port (0 none, 1 core, 2 aux) and the access in flight
    typedef struct { logic we, sb, sh; logic [63:0] addr, data; } cmd_t;
    int          m_owner, m_last, m_burst;
    cmd_t        m_cmd;
    logic        m_cack, m_aack;
    logic [63:0] m_crd, m_ard;
    logic [63:0] m_mem [512];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic cr, ar, prio, ce, ae;
        int   win;
        if (rst) begin
            m_owner = 0; m_last = 2; m_burst = 0;
            m_cmd = '{we: 1'b0, sb: 1'b0, sh: 1'b0, addr: 64'd0, data: 64'd0};
            m_cack = 1'b0; m_aack = 1'b0; m_crd = '0; m_ard = '0;
        end else if (clk_en) begin
            cr   = bus.i_core_req;
            ar   = bus.i_aux_req;
            prio = bus.i_aux_lock && (m_burst < MAXB);
            ce   = cr && (m_owner != 1);
            ae   = ar && (m_owner != 2);
            win  = 0;
            if (m_owner == 2 && cr && prio) win = 0;
            else if (ce && ae)              win = (prio || m_last == 1) ? 2 : 1;
            else if (ce)                    win = 1;
            else if (ae)                    win = 2;
            m_cack = (m_owner == 1);
            m_aack = (m_owner == 2);
            if (m_owner == 1) m_crd = m_mem[m_cmd.addr[8:0]];
            if (m_owner == 2) m_ard = m_mem[m_cmd.addr[8:0]];
            if (m_owner != 0 && m_cmd.we) m_mem[m_cmd.addr[8:0]] = m_cmd.data;
            if (!bus.i_aux_lock || win == 1) m_burst = 0;
            else if (win == 2 && cr && m_burst < MAXB) m_burst++;
            if (win == 1) m_cmd = '{we: bus.i_core_we, sb: bus.i_core_store_byte, sh: bus.i_core_store_half,
                                    addr: bus.i_core_addr, data: bus.i_core_wdata};
            if (win == 2) m_cmd = '{we: bus.i_aux_we, sb: bus.i_aux_store_byte, sh: bus.i_aux_store_half,
                                    addr: bus.i_aux_addr, data: bus.i_aux_wdata};
            if (win != 0) m_last = win;
            m_owner = win;
        end
    endtask

    task automatic check_all();
        chk("stall",      64'(bus.o_core_stall), 64'(bus.i_core_req && !m_cack));
        chk("core_ack",   64'(bus.o_core_ack),   64'(m_cack));
        chk("aux_ack",    64'(bus.o_aux_ack),    64'(m_aack));
        chk("core_rdata", bus.o_core_rdata, m_crd);
        chk("aux_rdata",  bus.o_aux_rdata,  m_ard);
        chk("mem_write",  64'(bus.o_mem_write),  64'(m_owner != 0 && m_cmd.we && !rst));
        chk("mem_addr",   bus.o_mem_addr, m_cmd.addr);
        chk("mem_data",   bus.o_mem_data, m_cmd.data);
        chk("store_byte", 64'(bus.o_store_byte), 64'(m_owner != 0 && m_cmd.sb));
        chk("store_half", 64'(bus.o_store_half), 64'(m_owner != 0 && m_cmd.sh));
        chk("burst_cnt",  64'(dut.burst_cnt),    64'(m_burst));
    endtask

    // inputs are set at the falling edge; check, advance model, clock, apply RAM write
    task automatic step(input bit do_chk);
        logic       we_now;
        logic [8:0] wa;
        logic [63:0] wd;
        #1;
        if (do_chk) check_all();
        we_now = clk_en && bus.o_mem_write;
        wa     = bus.o_mem_addr[8:0];
        wd     = bus.o_mem_data;
        model_edge();
        @(posedge clk);
        #1;
        if (we_now) begin
            ram[wa] = wd;
            if (wa == 9'h040) wr40++;
        end
        @(negedge clk);
    endtask

    task automatic req_core(input logic we, input logic [63:0] a, input logic [63:0] d, input logic sb, input logic sh);
        bus.i_core_req = 1'b1; bus.i_core_we = we; bus.i_core_addr = a; bus.i_core_wdata = d;
        bus.i_core_store_byte = sb; bus.i_core_store_half = sh;
    endtask

    task automatic req_aux(input logic we, input logic [63:0] a, input logic [63:0] d, input logic sb, input logic sh);
        bus.i_aux_req = 1'b1; bus.i_aux_we = we; bus.i_aux_addr = a; bus.i_aux_wdata = d;
        bus.i_aux_store_byte = sb; bus.i_aux_store_half = sh;
    endtask

    initial begin
        int ns, na;
        bit got;
        logic [63:0] v;
        for (int i = 0; i < 512; i++) begin
            v = {$urandom, $urandom};
            ram[i] = v;
            m_mem[i] = v;
        end
        rst = 1'b1; clk_en = 1'b1;
        req_core(1'b0, 64'd0, 64'd0, 1'b0, 1'b0); bus.i_core_req = 1'b0;
        req_aux(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);  bus.i_aux_req = 1'b0;
        bus.i_aux_lock = 1'b0;
        @(negedge clk);
        step(0);
        step(1);
        chk("rst_core_ack",   64'(bus.o_core_ack), 64'd0);
        chk("rst_aux_rdata",  bus.o_aux_rdata, 64'd0);
        chk("rst_mem_write",  64'(bus.o_mem_write), 64'd0);

        // core load
        rst = 1'b0;
        ram[9'h100] = 64'hDEADBEEF; m_mem[9'h100] = 64'hDEADBEEF;
        req_core(1'b0, 64'h100, 64'd0, 1'b0, 1'b0);
        ns = 0;
        #1 ns += int'(bus.o_core_stall);
        step(1);
        chk("load_addr", bus.o_mem_addr, 64'h100);
        ns += int'(bus.o_core_stall);
        step(1);
        chk("load_ack",   64'(bus.o_core_ack), 64'd1);
        chk("load_rdata", bus.o_core_rdata, 64'hDEADBEEF);
        ns += int'(bus.o_core_stall);
        chk("load_stall_cycles", 64'(ns), 64'd2);
        bus.i_core_req = 1'b0;
        step(1);

        // tie right after reset: core first, aux granted directly
        rst = 1'b1; step(1); rst = 1'b0;
        req_core(1'b0, 64'h10, 64'd0, 1'b0, 1'b0);
        req_aux(1'b1, 64'h18, 64'h1234, 1'b0, 1'b0);
        step(1);
        chk("tie_first_core", bus.o_mem_addr, 64'h10);
        step(1);
        chk("tie_core_ack",  64'(bus.o_core_ack), 64'd1);
        chk("tie_aux_grant", bus.o_mem_addr, 64'h18);
        chk("tie_aux_write", 64'(bus.o_mem_write), 64'd1);
        bus.i_core_req = 1'b0;
        step(1);
        chk("tie_aux_ack", 64'(bus.o_aux_ack), 64'd1);
        bus.i_aux_req = 1'b0;
        step(1);

        // aux lock burst
        bus.i_aux_lock = 1'b1;
        req_core(1'b0, 64'h20, 64'd0, 1'b0, 1'b0);
        req_aux(1'b0, 64'h28, 64'd0, 1'b0, 1'b0);
        na = 0; got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step(1);
            if (bus.o_aux_ack) begin
                na++;
                if (na == MAXB) chk("burst_cleared", 64'(dut.burst_cnt), 64'd0);
            end
            if (bus.o_core_ack) got = 1'b1;
        end
        chk("burst_aux_acks",    64'(na),  64'(MAXB));
        chk("burst_core_served", 64'(got), 64'd1);
        bus.i_core_req = 1'b0; bus.i_aux_req = 1'b0;
        step(1);
        bus.i_aux_lock = 1'b0;
        step(1); step(1);

        // clock enable held low mid-store
        wr40 = 0;
        req_core(1'b1, 64'h40, 64'h55, 1'b0, 1'b0);
        step(1);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("ce_hold_write", 64'(bus.o_mem_write), 64'd1);
            chk("ce_no_ack",     64'(bus.o_core_ack),  64'd0);
        end
        clk_en = 1'b1;
        step(1);
        chk("ce_ack",      64'(bus.o_core_ack), 64'd1);
        chk("ce_one_write", 64'(wr40), 64'd1);
        chk("ce_ram",      ram[9'h040], 64'h55);
        bus.i_core_req = 1'b0;
        step(1);

        // reset while aux store is in flight
        req_aux(1'b1, 64'h40, 64'h77, 1'b0, 1'b0);
        step(1);
        chk("aux_granted_write", 64'(bus.o_mem_write), 64'd1);
        rst = 1'b1;
        #1 chk("rst_no_write", 64'(bus.o_mem_write), 64'd0);
        step(1);
        rst = 1'b0; bus.i_aux_req = 1'b0;
        step(1);
        chk("rst_aux_ack",   64'(bus.o_aux_ack), 64'd0);
        chk("rst_aux_rdata", bus.o_aux_rdata, 64'd0);
        chk("rst_ram_kept",  ram[9'h040], 64'h55);
        chk("rst_writes",    64'(wr40), 64'd1);

        // aux byte store
        req_aux(1'b1, 64'h83, 64'hAB, 1'b1, 1'b0);
        step(1);
        chk("byte_flag", 64'(bus.o_store_byte), 64'd1);
        chk("half_flag", 64'(bus.o_store_half), 64'd0);
        chk("byte_data", bus.o_mem_data, 64'hAB);
        step(1);
        chk("byte_ack", 64'(bus.o_aux_ack), 64'd1);
        bus.i_aux_req = 1'b0;
        step(1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (!bus.i_core_req || m_cack) begin
                if ($urandom_range(0, 99) < 55)
                    req_core(1'($urandom), 64'($urandom_range(0, 511)), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
                else
                    bus.i_core_req = 1'b0;
            end
            if (!bus.i_aux_req || m_aack) begin
                if ($urandom_range(0, 99) < 55)
                    req_aux(1'($urandom), 64'($urandom_range(0, 511)), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
                else
                    bus.i_aux_req = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) bus.i_aux_lock = ~bus.i_aux_lock;
            clk_en = ($urandom_range(0, 99) < 85);
            rst    = ($urandom_range(0, 99) < 2);
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/data_ram_port_arbiter.md
Name: data_ram_port_arbiter

Overview:
- Shares the single data-RAM port (write enable, address, write data, byte/half store flags, read data) between two requesters.
- The core memory stage is one requester. An auxiliary master (program/data loader, debug or DMA engine) is the other.
- Sits between the SoC pipe register/mem-mapper output and the data RAM instance.
- Provides round-robin arbitration, an auxiliary lock with a bounded burst, registered read return and a core stall signal. All sequential logic is gated by the SoC clock enable.

Parameters:
XLEN, 2'b10 (`XLEN_64b), ISA width code; DW = 1<<(XLEN+4) is the data/address width.
MAX_BURST, 8, maximum consecutive aux grants under i_aux_lock while the core is waiting (>=1).
CNT_W, 4, burst counter width; must hold MAX_BURST.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_clk_en  in  1  pipeline clock enable; registers update only when high
i_core_req  in  1  core access request, held until o_core_ack
i_core_we  in  1  1=store, 0=load
i_core_addr  in  DW  translated RAM address
i_core_wdata  in  DW  store data
i_core_store_byte  in  1  byte store
i_core_store_half  in  1  halfword store
o_core_ack  out  1  one-enabled-cycle completion pulse
o_core_rdata  out  DW  load data, valid while o_core_ack=1
o_core_stall  out  1  i_core_req & ~o_core_ack (combinational)
i_aux_req, i_aux_we, i_aux_addr, i_aux_wdata, i_aux_store_byte, i_aux_store_half  in  1/1/DW/DW/1/1  aux request, same meaning as core
i_aux_lock  in  1  aux requests priority burst
o_aux_ack  out  1  aux completion pulse
o_aux_rdata  out  DW  aux load data
o_mem_write  out  1  RAM write enable
o_mem_addr  out  DW  RAM address
o_mem_data  out  DW  RAM write data
o_store_byte  out  1  RAM byte store
o_store_half  out  1  RAM halfword store
i_mem_rdata  in  DW  RAM read data (combinational from o_mem_addr)

Behaviour:
- Hold condition: all state changes occur on posedge i_clk when i_clk_en=1 or i_rst=1. Reset wins over clk_en.
- Reset values:
  - state=IDLE, last_grant=AUX (core wins first tie), burst_cnt=0, command registers 0.
  - o_core_ack=o_aux_ack=0, o_core_rdata=o_aux_rdata=0.
  - o_mem_write=0 while i_rst=1.
- FSM states: IDLE, CORE, AUX. Each granted access occupies exactly one enabled cycle in CORE or AUX.
- Grant (IDLE, enabled edge):
  - Eligibility is per requester's req.
  - Only one requesting: grant it.
  - Both requesting: if i_aux_lock=1 and burst_cnt<MAX_BURST, grant AUX. Otherwise grant the one not equal to last_grant.
  - On grant: latch we/addr/wdata/byte/half of the winner into the command registers, set last_grant, next state CORE/AUX.
- In CORE/AUX:
  - o_mem_* are driven from the command registers.
  - o_mem_write = latched we.
  - Outside CORE/AUX: o_mem_write=0 and o_store_byte=o_store_half=0; o_mem_addr/o_mem_data hold the last command.
- Exit from CORE (enabled edge):
  - o_core_ack<=1, o_core_rdata<=i_mem_rdata (written unchanged for stores).
  - Core is ineligible at this edge (its req is still the same transaction).
  - If i_aux_req, grant AUX directly (latch the aux command). Else go to IDLE.
- Exit from AUX: symmetric (o_aux_ack, o_aux_rdata; core granted directly if i_core_req). Exception: if i_aux_lock=1, burst_cnt<MAX_BURST and core is waiting, go to IDLE so aux can regain the port.
- Ack timing:
  - Each ack pulse lasts one enabled cycle and is cleared at the next enabled edge.
  - The requester may present a new request in its ack cycle; that request is treated as new.
  - Latency from req (in IDLE) to ack is 2 enabled cycles.
- burst_cnt:
  - Increments on each aux grant made while i_core_req=1 and i_aux_lock=1, saturating at MAX_BURST.
  - Clears on any core grant or when i_aux_lock=0.
- Starvation bound: with lock held, the core waits at most MAX_BURST aux accesses.
- i_clk_en=0 mid-access: state, command and acks hold. The RAM is likewise gated, so no duplicate writes.
- Reset mid-access: the access is abandoned with no ack and no write.
- o_store_byte and o_store_half both high are passed through unchanged; decode belongs to the RAM.

Test Plan:
- Core load: core req to addr 0x100 with RAM word 0xDEADBEEF -> o_mem_addr=0x100 in CORE, o_core_ack pulses on the 2nd enabled edge, o_core_rdata=0xDEADBEEF, o_core_stall high for exactly 2 cycles.
- Tie after reset: both req at cycle 0 -> CORE granted first, then AUX granted directly on the next edge; acks one cycle apart; no IDLE gap.
- Lock burst, MAX_BURST=4: aux_lock=1 with continuous aux req, core req held -> exactly 4 aux acks, then a core grant; burst_cnt returns to 0.
- Clock enable: i_clk_en=0 for 5 cycles while in CORE with we=1, addr 0x40, data 0x55 -> o_mem_write stays asserted, no ack; ack arrives one enabled edge after enable resumes; exactly one RAM write.
- Reset in AUX with we=1 -> o_mem_write=0 during reset; afterwards state IDLE, acks 0, rdata 0, RAM addr 0x40 unchanged.
- Byte store: aux we=1, store_byte=1, addr 0x83, wdata 0xAB -> o_store_byte=1, o_store_half=0, o_mem_data=0xAB in AUX; o_aux_ack follows.
